// File: rtl/serial_add2b_ctrl_pkg.sv
// Shared types for the serial two-bit adder controller.
// FSM state encoding, digit width and counter sizing helper.
package add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIGIT = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_add2b_ctrl_if.sv
// Request/result bundle of the serial adder controller.
// master: start/a/b/cin out, busy/done/sum/cout in; slave: reverse.
interface serial_add2b_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_add2b_ctrl_add2b.sv
// Combinational two-bit ripple adder slice.
// Ports: x, y digits, cIn carry in; z digit sum, cOut carry out.
module add2b (
  input  logic [1:0] x,
  input  logic [1:0] y,
  input  logic       cIn,
  output logic [1:0] z,
  output logic       cOut
);
  logic [1:0] s0;
  logic [1:0] s1;

  assign s0 = {1'b0, x[0]} + {1'b0, y[0]}
            + {1'b0, cIn};
  assign s1 = {1'b0, x[1]} + {1'b0, y[1]}
            + {1'b0, s0[1]};
  assign z    = {s1[0], s0[0]};
  assign cOut = s1[1];
endmodule

// File: rtl/serial_add2b_ctrl.sv
// Sequences add2b over WIDTH/2 digits, LSB first, one per clock.
// Ports: clk, rst (async high), bus (slave: start/a/b/cin -> busy/done/sum/cout).
module serial_add2b_ctrl
  import add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  serial_add2b_ctrl_if.slave bus
);
  localparam int ND = WIDTH / DIGIT;
  localparam int CL = clog2(ND);
  localparam int CW = (CL < 1) ? 1 : CL;

  if ((WIDTH % DIGIT) != 0 || WIDTH < DIGIT) begin : g_bad_width
    $error("serial_add2b_ctrl: WIDTH must be even and >= 2");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] ps_q, ps_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       z;
  logic             co;
  logic             last;
  logic             accept;

  add2b u_slice (
    .x    (sa_q[1:0]),
    .y    (sb_q[1:0]),
    .cIn  (c_q),
    .z    (z),
    .cOut (co)
  );

  assign last   = (cnt_q == CW'(ND - 1));
  assign accept = (state_q != RUN) && bus.start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == IDLE): if (bus.start) state_d = RUN;
      (state_q == RUN):  if (last) state_d = DONE;
      (state_q == DONE): state_d = bus.start ? RUN : IDLE;
      default:           state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == RUN);
    bus.done = (state_q == DONE);
    bus.sum  = sum_q;
    bus.cout = cout_q;
  end

  always_comb begin
    sa_d   = sa_q;
    sb_d   = sb_q;
    ps_d   = ps_q;
    c_d    = c_q;
    cnt_d  = cnt_q;
    sum_d  = sum_q;
    cout_d = cout_q;
    if (accept) begin
      sa_d  = bus.a;
      sb_d  = bus.b;
      c_d   = bus.cin;
      cnt_d = '0;
      ps_d  = '0;
    end else if (state_q == RUN) begin
      sa_d  = sa_q >> DIGIT;
      sb_d  = sb_q >> DIGIT;
      // new digit enters at the top so the LSB digit ends at bit 0
      ps_d  = (ps_q >> DIGIT)
            | (WIDTH'(z) << (WIDTH - DIGIT));
      c_d   = co;
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        sum_d  = ps_d;
        cout_d = co;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa_q   <= '0;
      sb_q   <= '0;
      ps_q   <= '0;
      c_q    <= 1'b0;
      cnt_q  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sa_q   <= sa_d;
      sb_q   <= sb_d;
      ps_q   <= ps_d;
      c_q    <= c_d;
      cnt_q  <= cnt_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end
endmodule

// File: tb/tb_serial_add2b_ctrl.sv
// Bench for serial_add2b_ctrl at WIDTH=8 and WIDTH=2.
// Countdown model checks WIDTH=8 every cycle; directed cases pin it.
module tb_serial_add2b_ctrl;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic chk_en;

  serial_add2b_ctrl_if #(.WIDTH(8)) if8 ();
  serial_add2b_ctrl_if #(.WIDTH(2)) if2 ();

  serial_add2b_ctrl #(.WIDTH(8)) u8 (
    .clk (clk),
    .rst (rst),
    .bus (if8.slave)
  );

  serial_add2b_ctrl #(.WIDTH(2)) u2 (
    .clk (clk),
    .rst (rst),
    .bus (if2.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h",
               nm, act, exp);
    end
  endtask

  // Model: an accepted start schedules a+b+cin to appear
  // WIDTH/2 edges later; starts are ignored while counting.
  logic [7:0] m_sum;
  logic       m_cout;
  logic       m_busy;
  logic       m_done;
  logic [8:0] m_pend;
  int         m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sum  <= '0;
      m_cout <= 1'b0;
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_pend <= '0;
      m_cnt  <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          {m_cout, m_sum} <= m_pend;
          m_done <= 1'b1;
          m_busy <= 1'b0;
        end
      end else if (if8.start) begin
        m_pend <= {1'b0, if8.a} + {1'b0, if8.b}
                + {8'd0, if8.cin};
        m_cnt  <= 4;
        m_busy <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_busy", 32'(if8.busy), 32'(m_busy));
      check("m_done", 32'(if8.done), 32'(m_done));
      check("m_sum",  32'(if8.sum),  32'(m_sum));
      check("m_cout", 32'(if8.cout), 32'(m_cout));
    end
  end

  task automatic add8(input string nm,
                      input logic [7:0] a,
                      input logic [7:0] b,
                      input logic ci,
                      input logic [8:0] exp);
    int n, bn;
    logic got;
    @(posedge clk); #1;
    if8.a = a; if8.b = b; if8.cin = ci;
    if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    n = 0; bn = 0; got = 1'b0;
    while (n < 20 && !got) begin
      @(negedge clk);
      n++;
      if (if8.busy) bn++;
      if (if8.done) got = 1'b1;
    end
    check({nm, "_lat"}, 32'(n), 32'd5);
    check({nm, "_busy"}, 32'(bn), 32'd4);
    check({nm, "_res"}, 32'({if8.cout, if8.sum}),
          32'(exp));
  endtask

  task automatic add2(input logic [1:0] a,
                      input logic [1:0] b,
                      input logic ci);
    int n;
    logic got;
    logic [2:0] exp;
    exp = {1'b0, a} + {1'b0, b} + {2'b0, ci};
    @(posedge clk); #1;
    if2.a = a; if2.b = b; if2.cin = ci;
    if2.start = 1'b1;
    @(posedge clk); #1;
    if2.start = 1'b0;
    n = 0; got = 1'b0;
    while (n < 10 && !got) begin
      @(negedge clk);
      n++;
      if (if2.done) got = 1'b1;
    end
    check("w2_lat", 32'(n), 32'd2);
    check("w2_res", 32'({if2.cout, if2.sum}),
          32'(exp));
  endtask

  logic [7:0] ha [3];
  logic [7:0] hb [3];
  logic       hc [3];
  logic [8:0] he [3];

  initial begin
    int nd;
    logic [7:0] ra, rb;
    logic rc;
    total = 0; bad = 0; chk_en = 1'b0;
    rst = 1'b0;
    if8.start = 0; if8.a = 0; if8.b = 0; if8.cin = 0;
    if2.start = 0; if2.a = 0; if2.b = 0; if2.cin = 0;
    ha = '{8'h01, 8'h80, 8'h7F};
    hb = '{8'h01, 8'h80, 8'h00};
    hc = '{1'b0, 1'b1, 1'b1};
    he = '{9'h002, 9'h101, 9'h080};
    #2 rst = 1'b1;
    #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("rst_busy", 32'(if8.busy), 32'd0);
    check("rst_done", 32'(if8.done), 32'd0);
    check("rst_sum",  32'(if8.sum),  32'd0);
    check("rst_cout", 32'(if8.cout), 32'd0);
    check("rst_w2",   32'({if2.busy, if2.done,
                           if2.cout, if2.sum}), 32'd0);

    add8("ff01", 8'hFF, 8'h01, 1'b0, 9'h100);
    add8("5a3c", 8'h5A, 8'h3C, 1'b1, 9'h097);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_sum",  32'(if8.sum),  32'h97);
      check("hold_done", 32'(if8.done), 32'd0);
    end

    @(posedge clk); #1;
    if8.a = 8'h5A; if8.b = 8'h3C; if8.cin = 1'b1;
    if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    if8.a = 8'h00; if8.b = 8'h00; if8.cin = 1'b0;
    if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (if8.done) begin
        nd++;
        check("ign_res", 32'({if8.cout, if8.sum}),
              32'h097);
      end
    end
    check("ign_ndone", 32'(nd), 32'd1);

    @(posedge clk); #1;
    if8.a = ha[0]; if8.b = hb[0]; if8.cin = hc[0];
    if8.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i < 2) begin
        if8.a = ha[i+1]; if8.b = hb[i+1];
        if8.cin = hc[i+1];
      end else begin
        if8.start = 1'b0;
      end
      repeat (4) @(posedge clk);
      #1;
      check("bb_done", 32'(if8.done), 32'd1);
      check("bb_res", 32'({if8.cout, if8.sum}),
            32'(he[i]));
    end

    @(posedge clk); #1;
    if8.a = 8'hC3; if8.b = 8'h77; if8.cin = 1'b1;
    if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_busy", 32'(if8.busy), 32'd0);
    check("arst_done", 32'(if8.done), 32'd0);
    check("arst_sum",  32'(if8.sum),  32'd0);
    check("arst_cout", 32'(if8.cout), 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (if8.done) nd++;
    end
    check("arst_nodone", 32'(nd), 32'd0);
    add8("post", 8'h12, 8'h34, 1'b0, 9'h046);

    for (int i = 0; i < 32; i++) begin
      add2(2'(i >> 3), 2'(i >> 1), i[0]);
    end

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      add8("rnd", ra, rb, rc,
           {1'b0, ra} + {1'b0, rb} + {8'd0, rc});
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
